// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and load/store,
// one transaction outstanding, LS priority with a starvation bound on IF.
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_req_valid,
    input  logic [WIDTH-1:0]   if_req_addr,
    output logic               if_req_ready,
    output logic               if_rsp_valid,
    output logic [WIDTH-1:0]   if_rsp_data,
    input  logic               ls_req_valid,
    input  logic [WIDTH-1:0]   ls_req_addr,
    input  logic               ls_req_wen,
    input  logic [WIDTH-1:0]   ls_req_wdata,
    input  logic [WIDTH/8-1:0] ls_req_wmask,
    output logic               ls_req_ready,
    output logic               ls_rsp_valid,
    output logic [WIDTH-1:0]   ls_rsp_rdata,
    output logic               mem_req_valid,
    output logic [WIDTH-1:0]   mem_req_addr,
    output logic               mem_req_wen,
    output logic [WIDTH-1:0]   mem_req_wdata,
    output logic [WIDTH/8-1:0] mem_req_wmask,
    input  logic               mem_req_ready,
    input  logic               mem_rsp_valid,
    input  logic [WIDTH-1:0]   mem_rsp_rdata,
    output logic               owner,
    output logic               proto_err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      starve_q, starve_d, starve_inc;
    logic [WIDTH-1:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [WIDTH-1:0]   if_data_q, if_data_d, ls_data_q, ls_data_d;
    logic [WIDTH/8-1:0] wmask_q, wmask_d;
    logic               wen_q, wen_d, owner_q, owner_d, err_q, err_d;
    logic               if_pulse_q, if_pulse_d, ls_pulse_q, ls_pulse_d;
    logic               idle, ls_win, if_win;

    // Grant is gated by rst_n so the readies also read 0 while reset is held.
    assign idle       = rst_n && state_q == IDLE;
    assign ls_win     = idle && ls_req_valid && !(if_req_valid && int'(starve_q) == STARVE_MAX);
    assign if_win     = idle && if_req_valid && !ls_win;
    assign starve_inc = int'(starve_q) == STARVE_MAX ? starve_q : starve_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        owner_d    = owner_q;
        if_data_d  = if_data_q;
        ls_data_d  = ls_data_q;
        if_pulse_d = 1'b0;
        ls_pulse_d = 1'b0;
        err_d      = err_q || (mem_rsp_valid && state_q != WAIT);
        if (ls_win || if_win) begin
            state_d  = ISSUE;
            owner_d  = ls_win;
            addr_d   = ls_win ? ls_req_addr : if_req_addr;
            wen_d    = ls_win && ls_req_wen;
            wdata_d  = ls_win ? ls_req_wdata : '0;
            wmask_d  = ls_win ? ls_req_wmask : '0;
            starve_d = if_win ? '0 : (if_req_valid ? starve_inc : starve_q);
        end
        if (state_q == ISSUE && mem_req_ready)
            state_d = WAIT;
        if (state_q == WAIT && mem_rsp_valid) begin
            state_d    = IDLE;
            if_pulse_d = !owner_q;
            ls_pulse_d = owner_q;
            if_data_d  = owner_q ? if_data_q : mem_rsp_rdata;
            ls_data_d  = owner_q && !wen_q ? mem_rsp_rdata : ls_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            owner_q    <= 1'b0;
            if_data_q  <= '0;
            ls_data_q  <= '0;
            if_pulse_q <= 1'b0;
            ls_pulse_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            owner_q    <= owner_d;
            if_data_q  <= if_data_d;
            ls_data_q  <= ls_data_d;
            if_pulse_q <= if_pulse_d;
            ls_pulse_q <= ls_pulse_d;
            err_q      <= err_d;
        end
    end

    assign if_req_ready  = if_win;
    assign ls_req_ready  = ls_win;
    assign if_rsp_valid  = if_pulse_q;
    assign if_rsp_data   = if_data_q;
    assign ls_rsp_valid  = ls_pulse_q;
    assign ls_rsp_rdata  = ls_data_q;
    assign mem_req_valid = state_q == ISSUE;
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    assign owner         = owner_q;
    assign proto_err     = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random traffic against a transaction-level model with a response
// scoreboard, followed by directed reset and protocol-error scenarios.
module tb_mem_port_arbiter;
    localparam int W  = 32;
    localparam int SM = 4;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         if_req_valid = 1'b0, if_req_ready, if_rsp_valid;
    logic [W-1:0] if_req_addr = '0, if_rsp_data;
    logic         ls_req_valid = 1'b0, ls_req_wen = 1'b0, ls_req_ready, ls_rsp_valid;
    logic [W-1:0] ls_req_addr = '0, ls_req_wdata = '0, ls_rsp_rdata;
    logic [3:0]   ls_req_wmask = '0, mem_req_wmask;
    logic         mem_req_valid, mem_req_wen, mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
    logic [W-1:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata = '0;
    logic         owner, proto_err, outs_or;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(W), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_wen(ls_req_wen),
        .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .owner(owner), .proto_err(proto_err)
    );

    assign outs_or = |{if_req_ready, if_rsp_valid, if_rsp_data, ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
                       mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, owner, proto_err};

    int           errs = 0, checks = 0;
    logic [32:0]  sb[$];
    logic [W-1:0] mem[16], rmem[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] bmask(input logic [3:0] m);
        logic [W-1:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    // Response monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && (if_rsp_valid || ls_rsp_valid)) begin
            if (sb.size() == 0) chk("unexpected_rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
            else begin
                e = sb.pop_front();
                chk("rsp_which", 64'({if_rsp_valid, ls_rsp_valid}), e[32] ? 64'd1 : 64'd2);
                chk("rsp_owner", 64'(owner), 64'(e[32]));
                chk("rsp_data", 64'(e[32] ? ls_rsp_rdata : if_rsp_data), 64'(e[31:0]));
            end
        end
    end

    bit           free = 1, issuing = 0, waiting = 0, pulse_due = 0, if_acc = 0, ls_acc = 0;
    int           starve = 0, wcnt = 0, hs_idx = 0;
    logic [W-1:0] ls_last = '0, p_addr = '0, p_wdata = '0;
    logic         p_wen = 1'b0;
    logic [3:0]   p_wmask = '0;

    task automatic run_env(input int n, input bit g, input bit c);
        bit exp_ls, exp_if;
        int idx;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = $urandom;
            if (waiting) begin
                if (wcnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = mem[hs_idx];
                    waiting = 0;
                end else wcnt--;
            end
            mem_req_ready = $urandom_range(0, 2) != 0;
            if (if_acc || !if_req_valid) begin
                if_acc = 0;
                if_req_valid = g && (c || $urandom_range(0, 2) == 0);
                if_req_addr = 32'h8000_0000 + 32'(4 * $urandom_range(0, 15));
            end
            if (ls_acc || !ls_req_valid) begin
                ls_acc = 0;
                ls_req_valid = g && (c || $urandom_range(0, 2) == 0);
                ls_req_addr = 32'h8000_0000 + 32'(4 * $urandom_range(0, 15));
                ls_req_wen = 1'($urandom_range(0, 1));
                ls_req_wdata = $urandom;
                ls_req_wmask = 4'($urandom_range(1, 15));
            end
            @(negedge clk);
            if (pulse_due) begin free = 1; pulse_due = 0; end
            if (mem_rsp_valid) pulse_due = 1;
            chk("mem_req_valid", 64'(mem_req_valid), 64'(issuing));
            chk("proto_err_clean", 64'(proto_err), 64'd0);
            if (issuing) begin
                chk("mem_addr", 64'(mem_req_addr), 64'(p_addr));
                chk("mem_wen", 64'(mem_req_wen), 64'(p_wen));
                chk("mem_wmask", 64'(mem_req_wmask), 64'(p_wmask));
                if (p_wen) chk("mem_wdata", 64'(mem_req_wdata), 64'(p_wdata));
                if (mem_req_ready) begin
                    hs_idx = int'(mem_req_addr[5:2]);
                    if (mem_req_wen)
                        mem[hs_idx] = (mem[hs_idx] & ~bmask(mem_req_wmask)) | (mem_req_wdata & bmask(mem_req_wmask));
                    issuing = 0;
                    waiting = 1;
                    wcnt = $urandom_range(0, 2);
                end
            end
            exp_ls = free && ls_req_valid && !(if_req_valid && starve == SM);
            exp_if = free && if_req_valid && !exp_ls;
            chk("ls_req_ready", 64'(ls_req_ready), 64'(exp_ls));
            chk("if_req_ready", 64'(if_req_ready), 64'(exp_if));
            if (exp_ls) begin
                idx = int'(ls_req_addr[5:2]);
                {p_addr, p_wen, p_wdata, p_wmask} = {ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask};
                if (ls_req_wen) rmem[idx] = (rmem[idx] & ~bmask(ls_req_wmask)) | (ls_req_wdata & bmask(ls_req_wmask));
                else ls_last = rmem[idx];
                sb.push_back({1'b1, ls_last});
                if (if_req_valid && starve < SM) starve++;
                ls_acc = 1;
            end else if (exp_if) begin
                {p_addr, p_wen, p_wdata, p_wmask} = {if_req_addr, 1'b0, 32'd0, 4'd0};
                sb.push_back({1'b0, rmem[int'(if_req_addr[5:2])]});
                starve = 0;
                if_acc = 1;
            end
            if (exp_ls || exp_if) begin free = 0; issuing = 1; end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin mem[i] = $urandom; rmem[i] = mem[i]; end
        #2 chk("reset_outputs", 64'(outs_or), 64'd0);
        #10 rst_n = 1'b1;
        run_env(1500, 1, 0);
        run_env(400, 1, 1);
        run_env(60, 0, 0);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        // Reset in WAIT drops the outstanding LS read; a late response becomes a protocol error.
        @(posedge clk); #1;
        {mem_req_ready, mem_rsp_valid, if_req_valid} = 3'b100;
        {ls_req_valid, ls_req_wen, ls_req_addr, ls_req_wmask} = {1'b1, 1'b0, 32'h8000_0010, 4'hF};
        @(negedge clk) chk("dir_ls_ready", 64'(ls_req_ready), 64'd1);
        @(posedge clk); #1 ls_req_valid = 1'b0;
        @(negedge clk) chk("dir_issue", 64'(mem_req_valid), 64'd1);
        @(negedge clk);
        chk("dir_wait", 64'(mem_req_valid), 64'd0);
        chk("dir_owner", 64'(owner), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 64'(outs_or), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 {mem_rsp_valid, mem_rsp_rdata} = {1'b1, 32'h1234_5678};
        @(posedge clk); #1 mem_rsp_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_rsp_err", 64'(proto_err), 64'd1);
            chk("late_rsp_nopulse", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
        end
        // Response in IDLE sets a sticky error cleared only by reset.
        rst_n = 1'b0;
        #1 chk("err_cleared", 64'(proto_err), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 mem_rsp_valid = 1'b1;
        @(posedge clk); #1 mem_rsp_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_rsp_err", 64'(proto_err), 64'd1);
            chk("idle_rsp_nopulse", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
        end
        // Response together with mem_req_ready in ISSUE is an error but the transaction still proceeds.
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        {if_req_valid, if_req_addr, mem_req_ready} = {1'b1, 32'h8000_0000, 1'b1};
        @(negedge clk) chk("issue_if_ready", 64'(if_req_ready), 64'd1);
        @(posedge clk); #1;
        {if_req_valid, mem_rsp_valid, mem_rsp_rdata} = {1'b0, 1'b1, 32'hBAD0_0000};
        @(negedge clk) chk("issue_valid", 64'(mem_req_valid), 64'd1);
        @(posedge clk); #1;
        {mem_rsp_valid, mem_rsp_rdata} = {1'b1, 32'h0010_0073};
        sb.push_back({1'b0, 32'h0010_0073});
        @(negedge clk);
        chk("issue_both_err", 64'(proto_err), 64'd1);
        chk("issue_both_wait", 64'(mem_req_valid), 64'd0);
        @(posedge clk); #1 mem_rsp_valid = 1'b0;
        @(negedge clk) chk("issue_both_pulse", 64'(if_rsp_valid), 64'd1);
        @(negedge clk) chk("final_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
